// File: rtl/acumulador_saturado.sv
// Time-multiplexed per-channel saturating accumulator; emits one result per Cuenta-sample window.
// Latency 1 cycle from the final sample; optional averaging via `ACUM_PROMEDIO_EN; stalls input while result is held.
module acumulador_saturado #(
    parameter int Width     = 25,
    parameter int Magnitud  = 8,
    parameter int Presicion = 16,
    parameter int Canales   = 4,
    parameter int Cuenta    = 8,
    localparam int CW       = (Canales > 1) ? $clog2(Canales) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    canal,
    input  logic [Width-1:0] dato,
    input  logic             modo,
    input  logic             limpiar,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_canal,
    output logic [Width-1:0] out_dato,
    output logic             out_sat
);

    localparam int NW = $clog2(Cuenta);
    localparam logic [Width-1:0] MAXW = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] MINW = {1'b1, {(Width-1){1'b0}}};

    generate
        if (Width != 1 + Magnitud + Presicion) begin : g_formato
            $error("Width must equal 1 + Magnitud + Presicion");
        end
    endgenerate

    typedef enum logic {VACIO, LLENO} estado_t;

    estado_t          estado_q, estado_d;
    logic [Width-1:0] acc_q [Canales];
    logic [Width-1:0] acc_d [Canales];
    logic [NW-1:0]    cnt_q [Canales];
    logic [NW-1:0]    cnt_d [Canales];
    logic             sat_q [Canales];
    logic             sat_d [Canales];
    logic [Width-1:0] out_dato_q, out_dato_d;
    logic [CW-1:0]    out_canal_q, out_canal_d;
    logic             out_sat_q, out_sat_d;

    logic             acepta, canal_ok, desborde, completa;
    logic [Width:0]   a_ext, d_ext, suma;
    logic [Width-1:0] paso, resultado;

`ifdef ACUM_PROMEDIO_EN
    logic signed [Width:0] redondeo, desplazado;

    // Round half up, then shift; the clamp only guards the top of the range.
    always_comb begin
        redondeo   = $signed({paso[Width-1], paso}) + $signed((Width+1)'(1 << (NW-1)));
        desplazado = redondeo >>> NW;
        resultado  = (desplazado[Width] != desplazado[Width-1]) ? MAXW : desplazado[Width-1:0];
    end
`else
    assign resultado = paso;
`endif

    always_comb begin
        in_ready = (estado_q == VACIO) || out_ready;
        acepta   = in_valid && in_ready;
        canal_ok = 32'(canal) < Canales;

        // One extra bit holds any acc +/- dato exactly, so overflow is a sign-bit disagreement.
        a_ext    = {acc_q[canal][Width-1], acc_q[canal]};
        d_ext    = {dato[Width-1], dato};
        suma     = modo ? (a_ext - d_ext) : (a_ext + d_ext);
        desborde = suma[Width] != suma[Width-1];
        paso     = desborde ? (suma[Width] ? MINW : MAXW) : suma[Width-1:0];
        completa = acepta && !limpiar && canal_ok && (cnt_q[canal] == NW'(Cuenta - 1));

        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (limpiar) begin
            for (int i = 0; i < Canales; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end
        end else if (acepta && canal_ok) begin
            if (completa) begin
                acc_d[canal] = '0;
                cnt_d[canal] = '0;
                sat_d[canal] = 1'b0;
            end else begin
                acc_d[canal] = paso;
                cnt_d[canal] = cnt_q[canal] + NW'(1);
                sat_d[canal] = sat_q[canal] | desborde;
            end
        end

        out_dato_d  = out_dato_q;
        out_canal_d = out_canal_q;
        out_sat_d   = out_sat_q;
        if (completa) begin
            out_dato_d  = resultado;
            out_canal_d = canal;
            out_sat_d   = sat_q[canal] | desborde;
        end

        estado_d = estado_q;
        case (estado_q)
            VACIO:   if (completa) estado_d = LLENO;
            LLENO:   if (out_ready && !completa) estado_d = VACIO;
            default: estado_d = VACIO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= VACIO;
            out_dato_q  <= '0;
            out_canal_q <= '0;
            out_sat_q   <= 1'b0;
            for (int i = 0; i < Canales; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                sat_q[i] <= 1'b0;
            end
        end else begin
            estado_q    <= estado_d;
            out_dato_q  <= out_dato_d;
            out_canal_q <= out_canal_d;
            out_sat_q   <= out_sat_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = (estado_q == LLENO);
    assign out_dato  = out_dato_q;
    assign out_canal = out_canal_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_acumulador_saturado.sv
// Directed bench for acumulador_saturado with default parameters (averaging disabled).
module tb_acumulador_saturado;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, modo, limpiar, out_valid, out_ready, out_sat;
    logic [1:0]  canal, out_canal;
    logic [24:0] dato, out_dato;
    int          checks = 0;
    int          errors = 0;

    acumulador_saturado dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .canal(canal), .dato(dato), .modo(modo), .limpiar(limpiar),
        .out_valid(out_valid), .out_ready(out_ready), .out_canal(out_canal),
        .out_dato(out_dato), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic send(input int ch, input logic [24:0] d, input logic m);
        @(negedge clk);
        in_valid = 1'b1;
        canal    = ch[1:0];
        dato     = d;
        modo     = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; canal = '0; dato = '0; modo = 1'b0;
        limpiar = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_dato !== 25'd0) begin errors++; $display("FAIL reset_dato got %0d want 0", out_dato); end
        checks++; if (out_canal !== 2'd0) begin errors++; $display("FAIL reset_canal got %0d want 0", out_canal); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b want 0", out_sat); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_basic_sum();
        for (int i = 0; i < 8; i++) begin
            send(0, 25'd65536, 1'b0);
            if (i == 6) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %0b want 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
        checks++; if (out_dato !== 25'd524288) begin errors++; $display("FAIL basic_dato got %0d want 524288", out_dato); end
        checks++; if (out_canal !== 2'd0) begin errors++; $display("FAIL basic_canal got %0d want 0", out_canal); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %0b want 0", out_sat); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0b want 0", out_valid); end
    endtask

    task automatic test_pos_sat();
        for (int i = 0; i < 8; i++) send(1, 25'h07FFFFF, 1'b0);
        checks++; if (out_dato !== 25'd16777215) begin errors++; $display("FAIL possat_dato got %0d want 16777215", out_dato); end
        checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL possat_sat got %0b want 1", out_sat); end
        checks++; if (out_canal !== 2'd1) begin errors++; $display("FAIL possat_canal got %0d want 1", out_canal); end
        for (int i = 0; i < 8; i++) send(1, 25'd1, 1'b0);
        checks++; if (out_dato !== 25'd8) begin errors++; $display("FAIL possat_next_dato got %0d want 8", out_dato); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL possat_next_sat got %0b want 0", out_sat); end
    endtask

    task automatic test_neg_sat();
        for (int i = 0; i < 8; i++) send(2, 25'h1000000, 1'b1);
        checks++; if (out_dato !== 25'd16777215) begin errors++; $display("FAIL subsat_dato got %0d want 16777215", out_dato); end
        checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL subsat_sat got %0b want 1", out_sat); end
        for (int i = 0; i < 8; i++) send(2, 25'h1000000, 1'b0);
        checks++; if (out_dato !== 25'h1000000) begin errors++; $display("FAIL negsat_dato got %h want 1000000", out_dato); end
        checks++; if (out_sat !== 1'b1) begin errors++; $display("FAIL negsat_sat got %0b want 1", out_sat); end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 32; i++) begin
            send(i % 4, 25'((i % 4) + 1), 1'b0);
            if (i >= 28) begin
                checks++;
                if (out_valid !== 1'b1 || out_canal !== 2'(i - 28) || out_dato !== 25'((i - 27) * 8)) begin
                    errors++;
                    $display("FAIL interleave_%0d got v=%0b c=%0d d=%0d want v=1 c=%0d d=%0d",
                             i, out_valid, out_canal, out_dato, i - 28, (i - 27) * 8);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 7; i++) send(0, 25'd3, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(3, 25'd2, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_dato !== 25'd16) begin errors++; $display("FAIL bp_first got v=%0b d=%0d want v=1 d=16", out_valid, out_dato); end
        @(negedge clk);
        in_valid = 1'b1; canal = 2'd0; dato = 25'd3; modo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dato !== 25'd16 || out_canal !== 2'd3) begin
                errors++;
                $display("FAIL bp_hold_%0d got r=%0b v=%0b d=%0d c=%0d want r=0 v=1 d=16 c=3",
                         i, in_ready, out_valid, out_dato, out_canal);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got %0b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_dato !== 25'd24 || out_canal !== 2'd0) begin errors++; $display("FAIL bp_reload got v=%0b d=%0d c=%0d want v=1 d=24 c=0", out_valid, out_dato, out_canal); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_dato !== 25'd24) begin errors++; $display("FAIL bp_hold2 got v=%0b d=%0d want v=1 d=24", out_valid, out_dato); end
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_limpiar();
        for (int i = 0; i < 5; i++) send(0, 25'd1, 1'b0);
        @(negedge clk);
        limpiar = 1'b1; in_valid = 1'b1; canal = 2'd0; dato = 25'd100; modo = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL limpiar_ready got %0b want 1", in_ready); end
        tick();
        @(negedge clk);
        limpiar = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(0, 25'd1, 1'b0);
            if (i == 6) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL limpiar_early got %0b want 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1 || out_dato !== 25'd8) begin errors++; $display("FAIL limpiar_dato got v=%0b d=%0d want v=1 d=8", out_valid, out_dato); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send(1, 25'd5, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(2, 25'd1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_canal !== 2'd2) begin errors++; $display("FAIL rst_pre got v=%0b c=%0d want v=1 c=2", out_valid, out_canal); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_dato !== 25'd0 || out_canal !== 2'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid got v=%0b d=%0d c=%0d s=%0b r=%0b want all 0 and r=1",
                     out_valid, out_dato, out_canal, out_sat, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(1, 25'd1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_dato !== 25'd8 || out_canal !== 2'd1 || out_sat !== 1'b0) begin errors++; $display("FAIL rst_after got v=%0b d=%0d c=%0d s=%0b want v=1 d=8 c=1 s=0", out_valid, out_dato, out_canal, out_sat); end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_pos_sat();
        test_neg_sat();
        test_interleave();
        test_back_pressure();
        test_limpiar();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
